// File: rtl/reg_file_multiport_sb_pkg.sv
// Shared defaults and port bundles for the multiport register file.
// Holds parameter constants and the decode/writeback-facing structs.
package PkgRegisterFileMp;

  localparam int RF_NUM_REGS  = 16;
  localparam int RF_DATA_W    = 32;
  localparam int RF_NUM_RD    = 3;
  localparam int RF_NUM_WR    = 2;
  localparam int RF_SEL_W     = $clog2(RF_NUM_REGS);

  typedef logic [RF_SEL_W-1:0]  rf_sel_t;
  typedef logic [RF_DATA_W-1:0] rf_data_t;

  typedef struct packed {
    logic     en;
    rf_sel_t  sel;
    rf_data_t data;
  } WrPort_RegFileMp;

  typedef struct packed {
    rf_sel_t         [RF_NUM_RD-1:0] rd_sel;
    WrPort_RegFileMp [RF_NUM_WR-1:0] wr;
    logic                            lock_en;
    rf_sel_t                         lock_sel;
  } PortIn_RegFileMp;

  typedef struct packed {
    rf_data_t [RF_NUM_RD-1:0] rd_data;
    logic     [RF_NUM_RD-1:0] rd_busy;
    logic                     any_busy;
  } PortOut_RegFileMp;

endpackage

// File: rtl/reg_file_multiport_sb_scoreboard.sv
// Pending-write scoreboard: one busy bit per register.
// Ports: clk/rst_n, wr_en_i/wr_sel_i (unlock), lock_en_i/lock_sel_i, busy_o, any_busy_o.
module reg_file_scoreboard
  import PkgRegisterFileMp::*;
#(
  parameter int NUM_REGS        = RF_NUM_REGS,
  parameter int NUM_WRITE_PORTS = RF_NUM_WR,
  parameter int SEL_WIDTH       = $clog2(NUM_REGS)
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic [NUM_WRITE_PORTS-1:0]                wr_en_i,
  input  logic [NUM_WRITE_PORTS-1:0][SEL_WIDTH-1:0] wr_sel_i,
  input  logic                                      lock_en_i,
  input  logic [SEL_WIDTH-1:0]                      lock_sel_i,
  output logic [NUM_REGS-1:0]                       busy_o,
  output logic                                      any_busy_o
);

  logic [NUM_REGS-1:0] sb_q;
  logic [NUM_REGS-1:0] sb_d;

  // Unlocks first, then the lock: a new producer issued on the
  // same edge as the old one retiring keeps the register busy.
  always_comb begin
    sb_d = sb_q;
    for (int p = 0; p < NUM_WRITE_PORTS; p++) begin
      if (wr_en_i[p] && (wr_sel_i[p] != '0)) begin
        sb_d[wr_sel_i[p]] = 1'b0;
      end
    end
    if (lock_en_i && (lock_sel_i != '0)) begin
      sb_d[lock_sel_i] = 1'b1;
    end
    sb_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_q <= '0;
    end else begin
      sb_q <= sb_d;
    end
  end

  assign busy_o     = sb_q;
  assign any_busy_o = |sb_q;

endmodule

// File: rtl/reg_file_multiport_sb.sv
// Frost32 multiport register file with pending-write scoreboard.
// Ports: rd_sel/rd_data/rd_busy (decode), wr_en/wr_sel/wr_data
// (writeback), lock_en/lock_sel (issue), any_busy.
// Option: FROST32_REG_FILE_WR_BYPASS_EN forwards same-cycle writes to reads.
module reg_file_multiport_sb
  import PkgRegisterFileMp::*;
#(
  parameter int NUM_REGS        = RF_NUM_REGS,
  parameter int DATA_WIDTH      = RF_DATA_W,
  parameter int NUM_READ_PORTS  = RF_NUM_RD,
  parameter int NUM_WRITE_PORTS = RF_NUM_WR,
  localparam int SEL_WIDTH      = $clog2(NUM_REGS)
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic [NUM_READ_PORTS-1:0][SEL_WIDTH-1:0]   rd_sel,
  output logic [NUM_READ_PORTS-1:0][DATA_WIDTH-1:0]  rd_data,
  output logic [NUM_READ_PORTS-1:0]                  rd_busy,
  input  logic [NUM_WRITE_PORTS-1:0]                 wr_en,
  input  logic [NUM_WRITE_PORTS-1:0][SEL_WIDTH-1:0]  wr_sel,
  input  logic [NUM_WRITE_PORTS-1:0][DATA_WIDTH-1:0] wr_data,
  input  logic                                       lock_en,
  input  logic [SEL_WIDTH-1:0]                       lock_sel,
  output logic                                       any_busy
);

  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_q;
  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_d;
  logic [NUM_REGS-1:0]                 busy;

  reg_file_scoreboard #(
    .NUM_REGS        (NUM_REGS),
    .NUM_WRITE_PORTS (NUM_WRITE_PORTS),
    .SEL_WIDTH       (SEL_WIDTH)
  ) u_sb (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en_i    (wr_en),
    .wr_sel_i   (wr_sel),
    .lock_en_i  (lock_en),
    .lock_sel_i (lock_sel),
    .busy_o     (busy),
    .any_busy_o (any_busy)
  );

  // Ascending port order: the highest enabled port wins a collision.
  always_comb begin
    regs_d = regs_q;
    for (int p = 0; p < NUM_WRITE_PORTS; p++) begin
      if (wr_en[p] && (wr_sel[p] != '0)) begin
        regs_d[wr_sel[p]] = wr_data[p];
      end
    end
    regs_d[0] = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int i = 0; i < NUM_READ_PORTS; i++) begin
      rd_data[i] = regs_q[rd_sel[i]];
      rd_busy[i] = busy[rd_sel[i]];
`ifdef FROST32_REG_FILE_WR_BYPASS_EN
      // Reset gates forwarding so reads stay 0 while it is held.
      for (int p = 0; p < NUM_WRITE_PORTS; p++) begin
        if (rst_n && wr_en[p] && (wr_sel[p] != '0)
            && (wr_sel[p] == rd_sel[i])) begin
          rd_data[i] = wr_data[p];
          rd_busy[i] = 1'b0;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_reg_file_multiport_sb.sv
// Self-checking bench for reg_file_multiport_sb.
// Directed scenarios plus random traffic against an array model.
module tb_reg_file_multiport_sb;

  localparam int NR = 16;
  localparam int DW = 32;
  localparam int RP = 3;
  localparam int WP = 2;
  localparam int SW = 4;

  logic                   clk;
  logic                   rst_n;
  logic [RP-1:0][SW-1:0]  rd_sel;
  logic [RP-1:0][DW-1:0]  rd_data;
  logic [RP-1:0]          rd_busy;
  logic [WP-1:0]          wr_en;
  logic [WP-1:0][SW-1:0]  wr_sel;
  logic [WP-1:0][DW-1:0]  wr_data;
  logic                   lock_en;
  logic [SW-1:0]          lock_sel;
  logic                   any_busy;

  int passed;
  int total;

  logic [DW-1:0] m_regs [NR];
  logic          m_sb   [NR];

  reg_file_multiport_sb dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_sel   (rd_sel),
    .rd_data  (rd_data),
    .rd_busy  (rd_busy),
    .wr_en    (wr_en),
    .wr_sel   (wr_sel),
    .wr_data  (wr_data),
    .lock_en  (lock_en),
    .lock_sel (lock_sel),
    .any_busy (any_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    for (int r = 0; r < NR; r++) begin
      m_regs[r] = '0;
      m_sb[r]   = 1'b0;
    end
  endtask

  // Architectural effect of one clock edge.
  task automatic model_edge();
    int s;
    for (int p = 0; p < WP; p++) begin
      s = int'(wr_sel[p]);
      if (wr_en[p] && s != 0) begin
        m_regs[s] = wr_data[p];
        m_sb[s]   = 1'b0;
      end
    end
    if (lock_en && int'(lock_sel) != 0) m_sb[int'(lock_sel)] = 1'b1;
  endtask

  task automatic idle();
    wr_en   = '0;
    wr_sel  = '0;
    wr_data = '0;
    lock_en = 1'b0;
    lock_sel = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_edge();
    @(negedge clk);
  endtask

  function automatic logic model_any();
    logic a = 1'b0;
    for (int r = 0; r < NR; r++) a |= m_sb[r];
    return a;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    rd_sel = '0;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    total++;
    if (any_busy !== 1'b0)
      $display("FAIL reset_hold_any got=%0b want=0", any_busy);
    else passed++;
    rst_n = 1'b1;
    for (int r = 1; r < NR; r++) begin
      for (int i = 0; i < RP; i++) rd_sel[i] = SW'(r);
      #1;
      total++;
      if (rd_data !== '0 || rd_busy !== '0 || any_busy !== 1'b0)
        $display("FAIL reset_r%0d got=%h busy=%b any=%b want=0",
                 r, rd_data, rd_busy, any_busy);
      else passed++;
    end
  endtask

  task automatic test_write_read();
    idle();
    wr_en[0]   = 1'b1;
    wr_sel[0]  = 4'd5;
    wr_data[0] = 32'hDEADBEEF;
    tick();
    idle();
    for (int i = 0; i < RP; i++) rd_sel[i] = 4'd5;
    #1;
    for (int i = 0; i < RP; i++) begin
      total++;
      if (rd_data[i] !== 32'hDEADBEEF)
        $display("FAIL wr_rd_p%0d got=%h want=deadbeef", i, rd_data[i]);
      else passed++;
    end
    wr_en[1]   = 1'b1;
    wr_sel[1]  = 4'd0;
    wr_data[1] = 32'h12345678;
    tick();
    idle();
    rd_sel[0] = 4'd0;
    #1;
    total++;
    if (rd_data[0] !== '0)
      $display("FAIL r0_write got=%h want=0", rd_data[0]);
    else passed++;
  endtask

  task automatic test_collision();
    idle();
    wr_en      = 2'b11;
    wr_sel[0]  = 4'd3;
    wr_sel[1]  = 4'd3;
    wr_data[0] = 32'h1111;
    wr_data[1] = 32'h2222;
    tick();
    idle();
    rd_sel[2] = 4'd3;
    #1;
    total++;
    if (rd_data[2] !== 32'h2222)
      $display("FAIL collision got=%h want=2222", rd_data[2]);
    else passed++;
  endtask

  task automatic test_scoreboard();
    idle();
    lock_en  = 1'b1;
    lock_sel = 4'd7;
    tick();
    idle();
    rd_sel[0] = 4'd7;
    #1;
    total++;
    if (rd_busy[0] !== 1'b1 || any_busy !== 1'b1)
      $display("FAIL lock_r7 got busy=%b any=%b want=1/1",
               rd_busy[0], any_busy);
    else passed++;
    wr_en[0]   = 1'b1;
    wr_sel[0]  = 4'd7;
    wr_data[0] = 32'hA5;
`ifndef FROST32_REG_FILE_WR_BYPASS_EN
    #1;
    total++;
    if (rd_busy[0] !== 1'b1)
      $display("FAIL busy_before_wb got=%b want=1", rd_busy[0]);
    else passed++;
`endif
    tick();
    idle();
    #1;
    total++;
    if (rd_busy[0] !== 1'b0 || any_busy !== 1'b0
        || rd_data[0] !== 32'hA5)
      $display("FAIL unlock_r7 got busy=%b any=%b d=%h want=0/0/a5",
               rd_busy[0], any_busy, rd_data[0]);
    else passed++;
    lock_en    = 1'b1;
    lock_sel   = 4'd7;
    wr_en[1]   = 1'b1;
    wr_sel[1]  = 4'd7;
    wr_data[1] = 32'h5A;
    tick();
    idle();
    #1;
    total++;
    if (rd_busy[0] !== 1'b1 || rd_data[0] !== 32'h5A)
      $display("FAIL lock_wr_same got busy=%b d=%h want=1/5a",
               rd_busy[0], rd_data[0]);
    else passed++;
    wr_en[0]   = 1'b1;
    wr_sel[0]  = 4'd7;
    wr_data[0] = 32'h5A;
    tick();
    idle();
    lock_en  = 1'b1;
    lock_sel = 4'd0;
    tick();
    idle();
    rd_sel[1] = 4'd0;
    #1;
    total++;
    if (rd_busy[1] !== 1'b0 || any_busy !== 1'b0)
      $display("FAIL lock_r0 got busy=%b any=%b want=0/0",
               rd_busy[1], any_busy);
    else passed++;
  endtask

  task automatic test_bypass();
    idle();
    wr_en[0]   = 1'b1;
    wr_sel[0]  = 4'd9;
    wr_data[0] = 32'h1234;
    tick();
    idle();
    wr_en[1]   = 1'b1;
    wr_sel[1]  = 4'd9;
    wr_data[1] = 32'hCAFE;
    rd_sel[0]  = 4'd9;
    #1;
    total++;
`ifdef FROST32_REG_FILE_WR_BYPASS_EN
    if (rd_data[0] !== 32'hCAFE)
      $display("FAIL bypass_same got=%h want=cafe", rd_data[0]);
    else passed++;
`else
    if (rd_data[0] !== 32'h1234)
      $display("FAIL bypass_same got=%h want=1234", rd_data[0]);
    else passed++;
`endif
    tick();
    idle();
    #1;
    total++;
    if (rd_data[0] !== 32'hCAFE)
      $display("FAIL bypass_next got=%h want=cafe", rd_data[0]);
    else passed++;
  endtask

  task automatic test_random();
    logic [DW-1:0] exp_d;
    logic          exp_b;
    int            s;
    for (int n = 0; n < 400; n++) begin
      for (int p = 0; p < WP; p++) begin
        wr_en[p]   = ($urandom_range(0, 2) == 0);
        wr_sel[p]  = SW'($urandom_range(0, NR - 1));
        wr_data[p] = $urandom;
      end
      if ($urandom_range(0, 3) == 0) wr_sel[1] = wr_sel[0];
      lock_en  = ($urandom_range(0, 1) == 1);
      lock_sel = SW'($urandom_range(0, NR - 1));
      for (int i = 0; i < RP; i++)
        rd_sel[i] = SW'($urandom_range(0, NR - 1));
      #1;
      for (int i = 0; i < RP; i++) begin
        s = int'(rd_sel[i]);
        exp_d = m_regs[s];
        exp_b = m_sb[s];
`ifdef FROST32_REG_FILE_WR_BYPASS_EN
        for (int p = 0; p < WP; p++) begin
          if (wr_en[p] && int'(wr_sel[p]) == s && s != 0) begin
            exp_d = wr_data[p];
            exp_b = 1'b0;
          end
        end
`endif
        total++;
        if (rd_data[i] !== exp_d || rd_busy[i] !== exp_b)
          $display("FAIL rand%0d_p%0d r%0d got=%h/%b want=%h/%b",
                   n, i, s, rd_data[i], rd_busy[i], exp_d, exp_b);
        else passed++;
      end
      total++;
      if (any_busy !== model_any())
        $display("FAIL rand%0d_any got=%b want=%b",
                 n, any_busy, model_any());
      else passed++;
      tick();
    end
    idle();
  endtask

  task automatic test_reset_mid();
    idle();
    lock_en    = 1'b1;
    lock_sel   = 4'd4;
    wr_en[0]   = 1'b1;
    wr_sel[0]  = 4'd4;
    wr_data[0] = 32'h55;
    tick();
    idle();
    rd_sel[0] = 4'd4;
    #1;
    total++;
    if (rd_data[0] !== 32'h55 || rd_busy[0] !== 1'b1)
      $display("FAIL pre_rst got=%h/%b want=55/1",
               rd_data[0], rd_busy[0]);
    else passed++;
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    total++;
    if (rd_data[0] !== '0 || rd_busy[0] !== 1'b0 || any_busy !== 1'b0)
      $display("FAIL mid_rst got=%h/%b any=%b want=0/0/0",
               rd_data[0], rd_busy[0], any_busy);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    #1;
    total++;
    if (rd_data[0] !== '0 || any_busy !== 1'b0)
      $display("FAIL post_rst got=%h any=%b want=0/0",
               rd_data[0], any_busy);
    else passed++;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    rst_n  = 1'b0;
    rd_sel = '0;
    idle();
    @(negedge clk);
    test_reset();
    @(negedge clk);
    test_write_read();
    test_collision();
    test_scoreboard();
    test_bypass();
    test_random();
    @(negedge clk);
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/reg_file_multiport_sb.md
Name: reg_file_multiport_sb

Overview:
- Next-generation Frost32 general-purpose register file.
- Parametrised in register count, data width, read-port count and write-port count.
- Adds a per-register pending-write scoreboard so decode can detect RAW hazards against in-flight writebacks.
- Sits between decode (read ports, lock requests) and writeback (write ports, unlock).

Parameters:
- NUM_REGS, 16, number of architectural registers; power of two, ≥2.
- DATA_WIDTH, 32, bits per register.
- NUM_READ_PORTS, 3, independent read ports.
- NUM_WRITE_PORTS, 2, independent write ports; higher index has priority.
- Derived localparam SEL_WIDTH = $clog2(NUM_REGS).

Ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rd_sel  in  NUM_READ_PORTS×SEL_WIDTH  register selected per read port.
- rd_data  out  NUM_READ_PORTS×DATA_WIDTH  read data per port.
- rd_busy  out  NUM_READ_PORTS  selected register has a pending write.
- wr_en  in  NUM_WRITE_PORTS  write enable per port.
- wr_sel  in  NUM_WRITE_PORTS×SEL_WIDTH  write target per port.
- wr_data  in  NUM_WRITE_PORTS×DATA_WIDTH  write data per port.
- lock_en  in  1  mark lock_sel as pending (instruction issued).
- lock_sel  in  SEL_WIDTH  register to lock.
- any_busy  out  1  OR of all scoreboard bits.

Behaviour:
- Reset: on rst_n low, asynchronously:
  - all registers cleared to 0 and all scoreboard bits cleared;
  - rd_data reads 0, rd_busy = 0, any_busy = 0 while reset is held.
  - Reset asserted mid-operation discards pending writes and locks; there is no recovery of in-flight state.
- Register 0:
  - always reads 0; writes to it are ignored;
  - lock requests to it are ignored, so it is never busy.
- Reads:
  - combinational, zero latency: rd_data[i] = regs[rd_sel[i]] as registered at the last edge;
  - rd_busy[i] = sb[rd_sel[i]].
- Writes:
  - on the rising edge, each port with wr_en=1 and wr_sel≠0 updates regs[wr_sel];
  - the same edge clears sb[wr_sel] (unlock).
- Write collisions: two enabled ports with the same wr_sel → highest-index port's data is stored; a single unlock occurs.
- Lock: on the rising edge with lock_en=1 and lock_sel≠0, sb[lock_sel] is set.
- Simultaneous lock and write to the same register on the same edge: data is written and the scoreboard bit ends SET (lock wins; a new producer has issued).
- Lock of an already-locked register: the bit stays set (no counting; the pipeline guarantees one producer in flight per register).
- Write to an unlocked register: legal; data is written and sb stays 0.
- Out-of-range selects cannot occur because NUM_REGS is a power of two.

Optional Feature:
- Macro: FROST32_REG_FILE_WR_BYPASS_EN.
- Defined:
  - rd_data[i] forwards same-cycle wr_data when a matching wr_en/wr_sel is present (wr_sel≠0); highest-index matching write port wins;
  - rd_busy[i] is forced to 0 when that port is forwarding.
- Undefined: reads return only registered contents; a same-cycle write is visible from the next cycle.

Decomposition:
- Package PkgRegisterFileMp holds:
  - default parameter constants;
  - typedef structs PortIn_RegFileMp (read sels, write bundle array, lock fields) and PortOut_RegFileMp (read data, busy, any_busy), parametrised through the package constants.
- One sub-module, reg_file_scoreboard:
  - holds the NUM_REGS-bit busy vector, the set/clear priority logic and any_busy;
  - the top instantiates it beside the storage array and the read muxes.

Test Plan:
- Reset state: hold rst_n=0 for 3 cycles, then read r1..r15 → all rd_data=0, rd_busy=0, any_busy=0.
- Write and read back:
  - write r5=0xDEADBEEF on port 0, then read r5 next cycle on all 3 ports → 0xDEADBEEF;
  - write r0=0x12345678 → r0 still reads 0.
- Write collision: port0 r3=0x1111 and port1 r3=0x2222 on the same edge → r3 reads 0x2222.
- Scoreboard:
  - lock r7 → rd_busy=1 and any_busy=1 next cycle;
  - write r7=0xA5 → busy clears next cycle;
  - lock r7 and write r7 on the same edge → r7=data and busy stays 1;
  - lock r0 → busy stays 0.
- Bypass:
  - with macro defined: write r9=0xCAFE while reading r9 in the same cycle → rd_data=0xCAFE;
  - with macro undefined: same cycle returns the old value, next cycle returns 0xCAFE.
- Reset mid-operation: lock r4 and write r4=0x55, then pulse rst_n low asynchronously mid-cycle → r4=0 and busy=0 immediately.
